// File: rtl/iir_integrator_inverse_seq.sv
// Time-multiplexed second-order recursive deconvolution filter.
// Undoes the front-end IIR integrator: y[n] = c0*x[n] + c1*x[n-1] + c2*x[n-2]
// + c3*y[n-1] + c4*y[n-2], with one shared 32x18 multiplier over five MAC cycles.
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   enable               1 = filter, 0 = bypass (sampled at input acceptance)
//   hist_clr             clear x1/x2/y1/y2 in the cycle it is high
//   in_valid/in_ready    input handshake, din signed 16-bit sample
//   out_valid/dout       one-cycle output strobe, dout held until next strobe
//   coef_we/addr/data    run-time coefficient write (Q2.15, index 0..4)
//   coef_err             one-cycle pulse when a write is dropped because busy
module iir_integrator_inverse_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        hist_clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] din,
  output logic        out_valid,
  output logic [15:0] dout,
  input  logic        coef_we,
  input  logic [2:0]  coef_addr,
  input  logic [17:0] coef_data,
  output logic        coef_err
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 18;
  localparam int unsigned HW    = 32;
  localparam int unsigned PW    = HW + CW;
  localparam int unsigned AW    = 52;
  localparam int unsigned NCOEF = 5;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             k_q;
  logic                   en_q;
  logic signed [HW-1:0]   xin_q, x1_q, x2_q, y1_q, y2_q;
  logic signed [AW-1:0]   acc_q;
  logic signed [CW-1:0]   coef_q [NCOEF];

  logic                   handshake_c;
  logic signed [HW-1:0]   op_c;
  logic signed [CW-1:0]   cf_c;
  logic signed [PW-1:0]   prod_c;
  logic signed [HW-1:0]   y_new_c;

  assign handshake_c = (state_q == IDLE) && in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (handshake_c) state_d = enable ? MAC : OUT;
      MAC:  if (k_q == 3'd4) state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/coefficient select for the shared multiplier
  always_comb begin
    op_c = xin_q;
    cf_c = coef_q[0];
    case (k_q)
      3'd1: begin op_c = x1_q; cf_c = coef_q[1]; end
      3'd2: begin op_c = x2_q; cf_c = coef_q[2]; end
      3'd3: begin op_c = y1_q; cf_c = coef_q[3]; end
      3'd4: begin op_c = y2_q; cf_c = coef_q[4]; end
      default: ;
    endcase
  end

  assign prod_c = PW'(op_c) * PW'(cf_c);

  // Clamp to the 47-bit signed range, then keep the Q16.16 slice [46:15]
  always_comb begin
    y_new_c = acc_q[46:15];
    if (!((acc_q[AW-1:46] == '0) || (acc_q[AW-1:46] == '1))) begin
      y_new_c = acc_q[AW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  // Datapath, history and coefficient registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q       <= '0;
      en_q      <= 1'b0;
      xin_q     <= '0;
      acc_q     <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
      coef_err  <= 1'b0;
      coef_q[0] <= 18'h08000;
      for (int i = 1; i < NCOEF; i++) coef_q[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (handshake_c) begin
            xin_q    <= {din, 16'b0};
            en_q     <= enable;
            acc_q    <= '0;
            k_q      <= '0;
            in_ready <= 1'b0;
          end
        end
        MAC: begin
          acc_q <= acc_q + AW'(prod_c);
          k_q   <= k_q + 3'd1;
        end
        OUT: begin
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          if (en_q) begin
            dout <= y_new_c[HW-1:HW-DW];
            x2_q <= x1_q;
            x1_q <= xin_q;
            y2_q <= y1_q;
            y1_q <= y_new_c;
          end else begin
            dout <= xin_q[HW-1:HW-DW];
          end
        end
        default: ;
      endcase

      // Writes only land while idle and not accepting a sample
      if (coef_we) begin
        if ((state_q == IDLE) && !handshake_c) begin
          for (int i = 0; i < NCOEF; i++) begin
            if (coef_addr == 3'(i)) coef_q[i] <= coef_data;
          end
        end else begin
          coef_err <= 1'b1;
        end
      end

      // Clear overrides any history update in the same cycle
      if (hist_clr) begin
        x1_q <= '0;
        x2_q <= '0;
        y1_q <= '0;
        y2_q <= '0;
      end
    end
  end

endmodule
